motor_axil_slave: RTL and testbench
===================================

# motor_axil_slave

AXI4-Lite responder for the motor IP: the slave end of the S00_AXI interface that the master BFM exercises. It holds four 32-bit read/write registers at offsets 0x0–0xC, answers every transfer with OKAY, and drives a PWM/direction/enable output stage from the control registers. It sits between the S00_AXI port of the motor IP and the motor driver pins.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register.
- PWM_CNT_WIDTH, 16, width of the PWM counter and of the period/duty fields.

Ports:
- ACLK  in  1  single clock for all logic.
- ARESET  in  1  reset, asynchronous and active-high.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte-lane enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- PWM_OUT  out  1  PWM drive.
- DIR_OUT  out  1  equals CTRL[1].
- EN_OUT  out  1  equals CTRL[0].

## Operation
- Register map. All registers are fully read/write and all 32 bits read back exactly as written.
  - 0x0 CTRL: bit0 enable, bit1 direction.
  - 0x4 PERIOD: bits [15:0] used.
  - 0x8 DUTY: bits [15:0] used.
  - 0xC SCRATCH.
- Address bits [1:0] are ignored. The PROT inputs are ignored.
- Write FSM has two states, W_IDLE and W_RESP.
  - In W_IDLE, AWREADY is high until an AW handshake is captured, and WREADY is high until a W handshake is captured. AW and W are accepted independently and in either order.
  - The register write is committed on the edge where the second of the two handshakes completes (both may complete on the same edge). On that same edge the FSM enters W_RESP with BVALID=1.
  - In W_RESP, AWREADY=WREADY=0. The FSM returns to W_IDLE on the edge where BVALID and BREADY are both high.
  - Each byte lane updates only where its WSTRB bit is 1.
- Read FSM has two states, R_IDLE and R_DATA.
  - In R_IDLE, ARREADY=1. On an AR handshake, RDATA is loaded with reg[ARADDR[3:2]], RVALID is set to 1, and ARREADY drops.
  - RDATA and RVALID hold until RVALID and RREADY are both high; the FSM then returns to R_IDLE.
- PWM stage:
  - The counter runs 0..P-1 and then wraps to 0, where P is the active period.
  - The active period is reloaded from PERIOD[15:0] only at wrap, or while the stage is disabled. The active duty is reloaded the same way.
  - PWM_OUT is registered and equals enable && (cnt < duty).

## Timing
- Reset values: all registers 0, both FSMs idle, and every output 0. That includes AWREADY, WREADY and ARREADY, which rise on the first clock after ARESET deasserts.
- Write latency: BVALID rises 1 cycle after the last of AW/W is accepted, and the new value is visible from that same edge.
- Read latency: RVALID rises 1 cycle after the AR handshake.
- Read and write to the same address committing on the same edge: the read returns the old value.
- A read issued after BVALID has been seen returns the new value.
- Back-to-back transfers: each FSM accepts its next address on the cycle after its response handshake. Maximum throughput is one write every 2 cycles and one read every 2 cycles.
- P=0: the counter is held at 0 and PWM_OUT=0.
- duty >= P: PWM_OUT is constantly 1 while enabled.
- Enable cleared: the counter goes to 0 and PWM_OUT goes to 0 on the next edge.
- ARESET asserted mid-transfer: the transfer is abandoned and any pending VALID outputs drop immediately. Registers are cleared, and no B or R response is produced for the abandoned transfer.

## Structure
- Package motor_pkg holds:
  - register offsets ADDR_CTRL/PERIOD/DUTY/SCRATCH;
  - RESP_OKAY = 2'b00;
  - CTRL bit indices;
  - the state enums for the write and read FSMs.
- Sub-module motor_pwm contains the counter, the shadow period/duty registers and the PWM_OUT register. Its inputs are en, period, duty.
- motor_axil_slave contains the AXI FSMs and the register file.

## Test plan
- Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0/0x4/0x8/0xC, and read each back -> each BRESP=00, RRESP=00, and the data matches.
- W presented 3 cycles before AW, then AW with BREADY held low for 5 cycles -> AWREADY and WREADY stay low during W_RESP, and exactly one BVALID pulse holds until BREADY.
- Write 0xFFFFFFFF to 0xC, then write 0x00000000 with WSTRB=0101 -> readback is 0xFF00FF00.
- PERIOD=10, DUTY=3, CTRL=1 -> PWM_OUT is 3 cycles high, 7 low, repeating. Change DUTY to 5 mid-period -> the new duty applies only from the next wrap.
- DUTY=12 with PERIOD=10 -> PWM_OUT stays at 1. PERIOD=0 -> PWM_OUT stays at 0. CTRL=2 -> DIR_OUT=1, EN_OUT=0, PWM_OUT=0.
- Assert ARESET while RVALID=1 and the counter is at 5 -> all outputs are 0 immediately, and a readback after reset returns 0 at every offset.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared constants, register map and FSM state types for the motor AXI4-Lite slave.
// Imported by the interface, the PWM stage and the top level.
package motor_pkg;

  localparam int AXI_DATA_W    = 32;
  localparam int AXI_ADDR_W    = 4;
  localparam int PWM_CNT_W     = 16;
  localparam int NUM_REGS      = 4;

  localparam logic [AXI_ADDR_W-1:0] ADDR_CTRL    = 4'h0;
  localparam logic [AXI_ADDR_W-1:0] ADDR_PERIOD  = 4'h4;
  localparam logic [AXI_ADDR_W-1:0] ADDR_DUTY    = 4'h8;
  localparam logic [AXI_ADDR_W-1:0] ADDR_SCRATCH = 4'hC;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_DIR_BIT = 1;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Word index of a byte address; the low two address bits are don't-care.
  function automatic logic [1:0] reg_index(input logic [AXI_ADDR_W-1:0] addr);
    return addr[3:2];
  endfunction

endpackage

// File: rtl/motor_axil_slave_if.sv
// AXI4-Lite bus bundle between the motor IP master and the motor_axil_slave responder.
// Widths default to the only supported configuration (32-bit data, 4-bit address).
interface motor_axil_slave_if
  import motor_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W
);

  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/motor_pwm.sv
// PWM output stage: free-running counter with shadow period/duty that only reload at
// wrap or while disabled, so bus writes never glitch the period in progress.
module motor_pwm
  import motor_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  output logic             pwm_out
);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [CNT_W-1:0] duty_reg, duty_next;
  logic             pwm_reg, pwm_next;
  logic             wrap;

  // A zero period is treated as a wrap every cycle: the counter sits at 0 and the
  // shadows keep tracking the bus registers so a new period takes effect promptly.
  assign wrap = (period_reg == '0) || (cnt_reg >= period_reg - 1'b1);

  always_comb begin
    cnt_next    = cnt_reg;
    period_next = period_reg;
    duty_next   = duty_reg;
    pwm_next    = 1'b0;
    if (!en) begin
      cnt_next    = '0;
      period_next = period;
      duty_next   = duty;
    end else begin
      pwm_next = (period_reg != '0) && (cnt_reg < duty_reg);
      if (wrap) begin
        cnt_next    = '0;
        period_next = period;
        duty_next   = duty;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      period_reg <= '0;
      duty_reg   <= '0;
      pwm_reg    <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      period_reg <= period_next;
      duty_reg   <= duty_next;
      pwm_reg    <= pwm_next;
    end
  end

  assign pwm_out = pwm_reg;

endmodule

// File: rtl/motor_axil_slave.sv
// AXI4-Lite responder for the motor IP: four R/W registers, OKAY-only responses,
// and the PWM/direction/enable drive derived from CTRL, PERIOD and DUTY.
module motor_axil_slave
  import motor_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = AXI_DATA_W,
  parameter int C_S_AXI_ADDR_WIDTH = AXI_ADDR_W,
  parameter int PWM_CNT_WIDTH      = PWM_CNT_W
) (
  input  logic              ACLK,
  input  logic              ARESET,
  motor_axil_slave_if.slave s_axi,
  output logic              PWM_OUT,
  output logic              DIR_OUT,
  output logic              EN_OUT
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] REG_CTRL   = reg_index(ADDR_CTRL);
  localparam logic [1:0] REG_PERIOD = reg_index(ADDR_PERIOD);
  localparam logic [1:0] REG_DUTY   = reg_index(ADDR_DUTY);

  // ---------------------------------------------------------------- write FSM
  wr_state_t                     wr_state_reg, wr_state_next;
  logic                          aw_done_reg, aw_done_next;
  logic                          w_done_reg, w_done_next;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_reg, awaddr_next;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [STRB_W-1:0]             wstrb_reg, wstrb_next;
  logic                          awready_reg, awready_next;
  logic                          wready_reg, wready_next;
  logic                          bvalid_reg, bvalid_next;

  logic                          aw_hs, w_hs;
  logic                          wr_commit;
  logic [1:0]                    wr_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]             wr_strb;

  assign aw_hs = s_axi.awvalid && awready_reg;
  assign w_hs  = s_axi.wvalid && wready_reg;

  always_comb begin
    wr_state_next = wr_state_reg;
    aw_done_next  = aw_done_reg;
    w_done_next   = w_done_reg;
    awaddr_next   = awaddr_reg;
    wdata_next    = wdata_reg;
    wstrb_next    = wstrb_reg;
    bvalid_next   = bvalid_reg;
    wr_commit     = 1'b0;
    wr_idx        = reg_index(awaddr_reg);
    wr_data       = wdata_reg;
    wr_strb       = wstrb_reg;

    case (wr_state_reg)
      W_IDLE: begin
        if (aw_hs) begin
          aw_done_next = 1'b1;
          awaddr_next  = s_axi.awaddr;
        end
        if (w_hs) begin
          w_done_next = 1'b1;
          wdata_next  = s_axi.wdata;
          wstrb_next  = s_axi.wstrb;
        end
        // Commit straight from the bus when a handshake completes this cycle,
        // otherwise from the half captured earlier.
        if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
          wr_commit     = 1'b1;
          wr_idx        = aw_hs ? reg_index(s_axi.awaddr) : reg_index(awaddr_reg);
          wr_data       = w_hs ? s_axi.wdata : wdata_reg;
          wr_strb       = w_hs ? s_axi.wstrb : wstrb_reg;
          aw_done_next  = 1'b0;
          w_done_next   = 1'b0;
          bvalid_next   = 1'b1;
          wr_state_next = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          bvalid_next   = 1'b0;
          wr_state_next = W_IDLE;
        end
      end
      default: wr_state_next = W_IDLE;
    endcase

    awready_next = (wr_state_next == W_IDLE) && !aw_done_next;
    wready_next  = (wr_state_next == W_IDLE) && !w_done_next;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state_reg <= W_IDLE;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
      awaddr_reg   <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
    end else begin
      wr_state_reg <= wr_state_next;
      aw_done_reg  <= aw_done_next;
      w_done_reg   <= w_done_next;
      awaddr_reg   <= awaddr_next;
      wdata_reg    <= wdata_next;
      wstrb_reg    <= wstrb_next;
      awready_reg  <= awready_next;
      wready_reg   <= wready_next;
      bvalid_reg   <= bvalid_next;
    end
  end

  // ------------------------------------------------------------ register file
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_rd [NUM_REGS];

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [C_S_AXI_DATA_WIDTH-1:0] data_reg;

    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
        data_reg <= '0;
      end else if (wr_commit && (wr_idx == 2'(gi))) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_strb[b]) begin
            data_reg[b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end

    assign regs_rd[gi] = data_reg;
  end

  // ----------------------------------------------------------------- read FSM
  rd_state_t                     rd_state_reg, rd_state_next;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic                          rvalid_reg, rvalid_next;
  logic                          arready_reg, arready_next;
  logic                          ar_hs;

  assign ar_hs = s_axi.arvalid && arready_reg;

  // The register file is sampled before this edge's write lands, so a read and
  // write committing together return the old contents.
  always_comb begin
    rd_state_next = rd_state_reg;
    rdata_next    = rdata_reg;
    rvalid_next   = rvalid_reg;
    case (rd_state_reg)
      R_IDLE: begin
        if (ar_hs) begin
          rdata_next    = regs_rd[reg_index(s_axi.araddr)];
          rvalid_next   = 1'b1;
          rd_state_next = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi.rready) begin
          rvalid_next   = 1'b0;
          rd_state_next = R_IDLE;
        end
      end
      default: rd_state_next = R_IDLE;
    endcase
    arready_next = (rd_state_next == R_IDLE);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state_reg <= R_IDLE;
      rdata_reg    <= '0;
      rvalid_reg   <= 1'b0;
      arready_reg  <= 1'b0;
    end else begin
      rd_state_reg <= rd_state_next;
      rdata_reg    <= rdata_next;
      rvalid_reg   <= rvalid_next;
      arready_reg  <= arready_next;
    end
  end

  // ------------------------------------------------------------------ outputs
  assign s_axi.awready = awready_reg;
  assign s_axi.wready  = wready_reg;
  assign s_axi.bvalid  = bvalid_reg;
  assign s_axi.bresp   = RESP_OKAY;
  assign s_axi.arready = arready_reg;
  assign s_axi.rvalid  = rvalid_reg;
  assign s_axi.rdata   = rdata_reg;
  assign s_axi.rresp   = RESP_OKAY;

  assign EN_OUT  = regs_rd[REG_CTRL][CTRL_EN_BIT];
  assign DIR_OUT = regs_rd[REG_CTRL][CTRL_DIR_BIT];

  motor_pwm #(
    .CNT_W (PWM_CNT_WIDTH)
  ) u_pwm (
    .clk     (ACLK),
    .rst     (ARESET),
    .en      (EN_OUT),
    .period  (regs_rd[REG_PERIOD][PWM_CNT_WIDTH-1:0]),
    .duty    (regs_rd[REG_DUTY][PWM_CNT_WIDTH-1:0]),
    .pwm_out (PWM_OUT)
  );

  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

endmodule

// File: tb/tb_motor_axil_slave.sv
// Self-checking bench for motor_axil_slave: AXI register access, handshake ordering,
// byte strobes, PWM waveform/boundaries and asynchronous reset mid-transfer.
module tb_motor_axil_slave;
  import motor_pkg::*;

  logic tb_ACLK;
  logic tb_ARESET;
  logic pwm_out, dir_out, en_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  logic        pwm_q[$];

  motor_axil_slave_if axi ();

  motor_axil_slave dut (
    .ACLK    (tb_ACLK),
    .ARESET  (tb_ARESET),
    .s_axi   (axi),
    .PWM_OUT (pwm_out),
    .DIR_OUT (dir_out),
    .EN_OUT  (en_out)
  );

  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (got hang, required finish)");
    $fatal(1);
  end

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int   guard;
    logic aw_hs, w_hs;
    @(negedge tb_ACLK);
    axi.awaddr  = addr;
    axi.wdata   = data;
    axi.wstrb   = strb;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    axi.bready  = 1'b1;
    guard = 0;
    while ((axi.awvalid || axi.wvalid) && guard < 20) begin
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      @(negedge tb_ACLK);
      if (aw_hs) axi.awvalid = 1'b0;
      if (w_hs)  axi.wvalid  = 1'b0;
      guard++;
    end
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    guard = 0;
    while (axi.bvalid !== 1'b1 && guard < 20) begin
      @(negedge tb_ACLK);
      guard++;
    end
    n_cmp++;
    if (axi.bvalid !== 1'b1 || guard != 0 || axi.bresp !== RESP_OKAY) begin
      n_bad++;
      $display("FAIL write_resp addr=%h: got bvalid=%b bresp=%b wait=%0d, required bvalid=1 bresp=00 wait=0",
               addr, axi.bvalid, axi.bresp, guard);
    end
    @(negedge tb_ACLK);
    $display("WRITE addr=%h data=%h strb=%b bresp=%b", addr, data, strb, axi.bresp);
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] expected);
    int          guard;
    logic        ar_hs;
    logic [31:0] exp_v;
    exp_q.push_back(expected);
    @(negedge tb_ACLK);
    axi.araddr  = addr;
    axi.arvalid = 1'b1;
    axi.rready  = 1'b1;
    guard = 0;
    while (axi.arvalid && guard < 20) begin
      ar_hs = axi.arvalid && axi.arready;
      @(negedge tb_ACLK);
      if (ar_hs) axi.arvalid = 1'b0;
      guard++;
    end
    axi.arvalid = 1'b0;
    guard = 0;
    while (axi.rvalid !== 1'b1 && guard < 20) begin
      @(negedge tb_ACLK);
      guard++;
    end
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (axi.rvalid !== 1'b1 || guard != 0 || axi.rdata !== exp_v || axi.rresp !== RESP_OKAY) begin
      n_bad++;
      $display("FAIL read addr=%h: got rvalid=%b rdata=%h rresp=%b wait=%0d, required rvalid=1 rdata=%h rresp=00 wait=0",
               addr, axi.rvalid, axi.rdata, axi.rresp, guard, exp_v);
    end
    @(negedge tb_ACLK);
    $display("READ  addr=%h rdata=%h rresp=%b", addr, axi.rdata, axi.rresp);
  endtask

  // Leaves the bench at the negedge just after PWM_OUT rose (counter then reads 1).
  task automatic sync_pwm_rise(input string tag);
    int guard = 0;
    while (pwm_out !== 1'b0 && guard < 60) begin @(negedge tb_ACLK); guard++; end
    while (pwm_out !== 1'b1 && guard < 120) begin @(negedge tb_ACLK); guard++; end
    n_cmp++;
    if (pwm_out !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_sync: got pwm=%b after %0d cycles, required a rising edge", tag, pwm_out, guard);
    end
  endtask

  task automatic test_reset;
    tb_ARESET   = 1'b1;
    axi.awaddr  = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata   = '0; axi.wstrb  = '0; axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    axi.araddr  = '0; axi.arprot = '0; axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    repeat (3) @(negedge tb_ACLK);
    n_cmp++;
    if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, pwm_out, dir_out, en_out} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b, required 00000000",
               {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, pwm_out, dir_out, en_out});
    end
    tb_ARESET = 1'b0;
    @(negedge tb_ACLK);
    n_cmp++;
    if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid} !== 5'b11100) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b, required 11100",
               {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid});
    end
    $display("RESET released");
  endtask

  task automatic test_regs;
    axi_write(ADDR_CTRL,    32'h0101FFFF, 4'hF);
    axi_write(ADDR_PERIOD,  32'hABCD0001, 4'hF);
    axi_write(ADDR_DUTY,    32'hDEAD0011, 4'hF);
    axi_write(ADDR_SCRATCH, 32'hBEEF0011, 4'hF);
    n_cmp++;
    if ({dir_out, en_out} !== 2'b11) begin
      n_bad++;
      $display("FAIL ctrl_pins: got dir/en=%b, required 11", {dir_out, en_out});
    end
    axi_read(ADDR_CTRL,    32'h0101FFFF);
    axi_read(ADDR_PERIOD,  32'hABCD0001);
    axi_read(ADDR_DUTY,    32'hDEAD0011);
    axi_read(ADDR_SCRATCH, 32'hBEEF0011);
    axi_read(4'hB,         32'hDEAD0011);
  endtask

  task automatic test_w_before_aw;
    axi.bready = 1'b0;
    @(negedge tb_ACLK);
    axi.wdata  = 32'h12345678;
    axi.wstrb  = 4'hF;
    axi.wvalid = 1'b1;
    @(negedge tb_ACLK);
    axi.wvalid = 1'b0;
    n_cmp++;
    if ({axi.awready, axi.wready, axi.bvalid} !== 3'b100) begin
      n_bad++;
      $display("FAIL w_first_ready: got aw/w/b=%b, required 100", {axi.awready, axi.wready, axi.bvalid});
    end
    repeat (2) @(negedge tb_ACLK);
    axi.awaddr  = ADDR_SCRATCH;
    axi.awvalid = 1'b1;
    @(negedge tb_ACLK);
    axi.awvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({axi.bvalid, axi.awready, axi.wready} !== 3'b100) begin
        n_bad++;
        $display("FAIL w_resp_hold[%0d]: got b/aw/w=%b, required 100", i, {axi.bvalid, axi.awready, axi.wready});
      end
      @(negedge tb_ACLK);
    end
    axi.bready = 1'b1;
    @(negedge tb_ACLK);
    n_cmp++;
    if ({axi.bvalid, axi.awready, axi.wready} !== 3'b011) begin
      n_bad++;
      $display("FAIL w_resp_release: got b/aw/w=%b, required 011", {axi.bvalid, axi.awready, axi.wready});
    end
    $display("WRITE addr=%h data=12345678 W-before-AW, bready delayed 5 cycles", ADDR_SCRATCH);
    axi_read(ADDR_SCRATCH, 32'h12345678);
  endtask

  task automatic test_strobe;
    axi_write(ADDR_SCRATCH, 32'hFFFFFFFF, 4'hF);
    axi_write(ADDR_SCRATCH, 32'h00000000, 4'b0101);
    axi_read(ADDR_SCRATCH, 32'hFF00FF00);
  endtask

  task automatic test_back_to_back;
    axi_write(ADDR_SCRATCH, 32'h11111111, 4'hF);
    fork
      axi_write(ADDR_SCRATCH, 32'h22222222, 4'hF);
      axi_read(ADDR_SCRATCH, 32'h11111111);
    join
    axi_read(ADDR_SCRATCH, 32'h22222222);
    n_cmp++;
    if (axi.arready !== 1'b1 || axi.awready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready: got arready=%b awready=%b, required 1 1", axi.arready, axi.awready);
    end
    axi_read(ADDR_CTRL, 32'h0101FFFF);
  endtask

  task automatic test_pwm;
    logic got;
    logic e;
    axi_write(ADDR_CTRL,   32'h0, 4'hF);
    axi_write(ADDR_PERIOD, 32'd10, 4'hF);
    axi_write(ADDR_DUTY,   32'd3, 4'hF);
    axi_write(ADDR_CTRL,   32'h1, 4'hF);
    sync_pwm_rise("pwm");
    // Duty 3 for the current period; the change to 5 lands at count 2 and must wait for wrap.
    for (int i = 0; i < 25; i++) pwm_q.push_back((i < 10) ? (i < 3) : ((i % 10) < 5));
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          got = pwm_out;
          e   = pwm_q.pop_front();
          n_cmp++;
          if (got !== e) begin
            n_bad++;
            $display("FAIL pwm_wave[%0d]: got %b, required %b", i, got, e);
          end
          @(negedge tb_ACLK);
        end
      end
      axi_write(ADDR_DUTY, 32'd5, 4'hF);
    join
    $display("PWM period=10 duty 3->5 waveform checked over 25 cycles");
  endtask

  task automatic test_pwm_bounds;
    axi_write(ADDR_DUTY, 32'd12, 4'hF);
    repeat (12) @(negedge tb_ACLK);
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (pwm_out !== 1'b1) begin
        n_bad++;
        $display("FAIL pwm_duty_ge_period[%0d]: got %b, required 1", i, pwm_out);
      end
      @(negedge tb_ACLK);
    end
    $display("PWM duty=12 period=10 held high");
    axi_write(ADDR_PERIOD, 32'd0, 4'hF);
    repeat (15) @(negedge tb_ACLK);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (pwm_out !== 1'b0) begin
        n_bad++;
        $display("FAIL pwm_period_zero[%0d]: got %b, required 0", i, pwm_out);
      end
      @(negedge tb_ACLK);
    end
    $display("PWM period=0 held low");
    axi_write(ADDR_CTRL, 32'h2, 4'hF);
    n_cmp++;
    if ({dir_out, en_out, pwm_out} !== 3'b100) begin
      n_bad++;
      $display("FAIL ctrl_dir_only: got dir/en/pwm=%b, required 100", {dir_out, en_out, pwm_out});
    end
  endtask

  task automatic test_reset_mid;
    axi_write(ADDR_CTRL,   32'h0, 4'hF);
    axi_write(ADDR_PERIOD, 32'd10, 4'hF);
    axi_write(ADDR_DUTY,   32'd8, 4'hF);
    axi_write(ADDR_CTRL,   32'h3, 4'hF);
    sync_pwm_rise("reset_mid");
    repeat (3) @(negedge tb_ACLK);
    axi.araddr  = ADDR_PERIOD;
    axi.arvalid = 1'b1;
    axi.rready  = 1'b0;
    @(negedge tb_ACLK);
    axi.arvalid = 1'b0;
    n_cmp++;
    if ({axi.rvalid, pwm_out, en_out} !== 3'b111) begin
      n_bad++;
      $display("FAIL pre_reset_state: got rvalid/pwm/en=%b, required 111", {axi.rvalid, pwm_out, en_out});
    end
    #2 tb_ARESET = 1'b1;
    #1;
    n_cmp++;
    if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, pwm_out, dir_out, en_out} !== 8'h00) begin
      n_bad++;
      $display("FAIL async_reset_outputs: got %b, required 00000000",
               {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, pwm_out, dir_out, en_out});
    end
    repeat (2) @(negedge tb_ACLK);
    tb_ARESET  = 1'b0;
    axi.rready = 1'b1;
    axi.bready = 1'b1;
    repeat (3) begin
      @(negedge tb_ACLK);
      n_cmp++;
      if ({axi.rvalid, axi.bvalid} !== 2'b00) begin
        n_bad++;
        $display("FAIL no_stale_resp: got rvalid/bvalid=%b, required 00", {axi.rvalid, axi.bvalid});
      end
    end
    $display("RESET asserted mid-read, released");
    axi_read(ADDR_CTRL,    32'h0);
    axi_read(ADDR_PERIOD,  32'h0);
    axi_read(ADDR_DUTY,    32'h0);
    axi_read(ADDR_SCRATCH, 32'h0);
  endtask

  initial begin
    test_reset();
    test_regs();
    test_w_before_aw();
    test_strobe();
    test_back_to_back();
    test_pwm();
    test_pwm_bounds();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
